fft_bfly_stage: RTL and testbench
=================================

FFT_BFLY_STAGE -- requirements
Module: fft_bfly_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 9: input sample width (signed, per I/Q component).
REQ-002 SHALL have parameter LANES, default 16: complex samples per beat.
REQ-003 SHALL have parameter SPAN, default 16: butterfly partner distance in beats; power of two, >= 2.
REQ-004 SHALL have parameter ROT_EN, default 1: 1 = trivial +/-j rotation applied to the second half of diff beats.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rstn  input  1  reset; synchronous, active-high (rstn=1 resets).
REQ-007 in_i, in_q  input  LANES x WIDTH signed  input beat, lane index 0..LANES-1.
REQ-008 din_valid  input  1  beat qualifier.
REQ-009 fft_mode  input  1  0 = FFT (rotate by -j), 1 = IFFT (rotate by +j).
REQ-010 dout_re, dout_im  output  LANES x (WIDTH+1) signed  registered result beat.
REQ-011 dout_valid  output  1  result qualifier.
REQ-012 dout_sel  output  1  0 = sum beat, 1 = diff beat.

Function
REQ-013 Frame SHALL be 2*SPAN input beats; beat k in 0..SPAN-1 is partner of beat k+SPAN, lane-for-lane.
REQ-014 Buffer: SPAN x LANES complex words, WIDTH+1 bits each; write pointer wp, read pointer rp, each 0..SPAN.
REQ-015 States: IDLE, FILL, BFLY, DRAIN.
REQ-016 IDLE: on din_valid, store beat at slot 0, wp=1, latch fft_mode into frame_mode, go FILL.
REQ-017 FILL: each din_valid stores beat at slot wp (sign-extended), wp++; on storing slot SPAN-1 go BFLY, wp=0.
REQ-018 BFLY: each din_valid beat j: sum=buf[j]+in, diff=buf[j]-in (full WIDTH+1 precision, no saturation); next cycle dout=sum, dout_sel=0, dout_valid=1; diff written to buf[j]; after j=SPAN-1 go DRAIN, rp=0.
REQ-019 BFLY without din_valid SHALL hold state and index and drive dout_valid=0 next cycle.
REQ-020 DRAIN: every cycle, regardless of din_valid, read buf[rp]; next cycle dout=diff (rotated per REQ-021), dout_sel=1, dout_valid=1; rp++; DRAIN lasts exactly SPAN cycles.
REQ-021 Rotation when ROT_EN=1 and rp >= SPAN/2: frame_mode=0 -> (re,im)->(im,-re); frame_mode=1 -> (re,im)->(-im,re); no width growth (operand magnitude <= 2^WIDTH-1).
REQ-022 din_valid during DRAIN SHALL be accepted as FILL beats of the next frame at slot wp (wp <= rp always; same-slot read-then-write returns the old diff); first such beat latches frame_mode for the new frame.
REQ-023 DRAIN exit: wp==SPAN -> BFLY, wp=0; 0<wp<SPAN -> FILL; wp==0 -> IDLE.
REQ-024 Contiguous input yields dout_valid high for 2*SPAN consecutive cycles per frame: SPAN sum beats, then SPAN diff beats; first sum appears 1 cycle after beat SPAN; back-to-back frames SHALL produce gap-free output.
REQ-025 fft_mode changes mid-frame SHALL not affect the current frame.
REQ-026 dout_re/dout_im SHALL hold their last value when dout_valid=0.

Reset
REQ-027 rstn=1 at a clock edge SHALL force IDLE, wp=rp=0, frame_mode=0, dout_valid=0, dout_sel=0, dout_re=dout_im=0 next cycle; buffer contents need not be cleared.
REQ-028 Reset asserted mid-FILL/BFLY/DRAIN SHALL abandon the frame; no further dout_valid until a new complete frame is received.

Verification (LANES=2, SPAN=2, WIDTH=9, ROT_EN=1 unless stated)
REQ-029 Beats (1,0),(2,0),(5,0),(7,0) real-only per lane, FFT mode -> sums 6,9 on cycles 4,5; diffs -4 then rotated -5 -> (0,+5) on cycles 6,7; dout_sel 0,0,1,1.
REQ-030 Same frame with fft_mode=1 -> last diff rotated to (0,-5); fft_mode toggled after beat 0 has no effect.
REQ-031 Extremes in=-256 then +255 (partner) -> diff -511, sum -1, no wrap.
REQ-032 Two frames back-to-back -> dout_valid high 8 consecutive cycles, second frame values correct (DRAIN/FILL overlap).
REQ-033 din_valid gap of 3 cycles inside BFLY -> dout_valid low 3 cycles, values unchanged; gap inside DRAIN -> diffs still emitted contiguously.
REQ-034 rstn=1 during DRAIN -> outputs zero next cycle, no further valid until 4 new beats.

Source files
------------

// File: rtl/fft_bfly_stage.sv
// Radix-2 butterfly stage over a streamed frame of 2*SPAN beats.
// The first half of each frame is buffered; second-half beats combine with
// their partners to emit sums immediately, while the diffs overwrite the
// buffer and are streamed out afterwards (optionally rotated by +/-j).

// Per-lane datapath: buffer column, add/sub and trivial rotation.
module fft_bfly_lane #(
    parameter int WIDTH = 9,
    parameter int SPAN  = 16,
    parameter int IW    = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    wr_diff,
    input  logic [IW-1:0]           wr_idx,
    input  logic [IW-1:0]           rd_idx,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    rot,
    input  logic                    rot_mode,
    output logic signed [WIDTH:0]   sum_re,
    output logic signed [WIDTH:0]   sum_im,
    output logic signed [WIDTH:0]   drn_re,
    output logic signed [WIDTH:0]   drn_im
);
    logic signed [WIDTH:0] mem_re [SPAN];
    logic signed [WIDTH:0] mem_im [SPAN];
    logic signed [WIDTH:0] rd_re, rd_im, ext_re, ext_im, diff_re, diff_im;

    assign rd_re   = mem_re[rd_idx];
    assign rd_im   = mem_im[rd_idx];
    assign ext_re  = {in_re[WIDTH-1], in_re};
    assign ext_im  = {in_im[WIDTH-1], in_im};
    assign sum_re  = rd_re + ext_re;
    assign sum_im  = rd_im + ext_im;
    assign diff_re = rd_re - ext_re;
    assign diff_im = rd_im - ext_im;

    // mode 0 multiplies by -j, mode 1 by +j; stored diffs never reach -2^WIDTH
    // so the negation cannot overflow.
    assign drn_re = rot ? (rot_mode ? -rd_im : rd_im) : rd_re;
    assign drn_im = rot ? (rot_mode ? rd_re : -rd_re) : rd_im;

    // Buffer write: raw first-half samples, or diffs replacing their partners.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_idx] <= wr_diff ? diff_re : ext_re;
            mem_im[wr_idx] <= wr_diff ? diff_im : ext_im;
        end
    end
endmodule

module fft_bfly_stage #(
    parameter int WIDTH  = 9,
    parameter int LANES  = 16,
    parameter int SPAN   = 16,
    parameter bit ROT_EN = 1'b1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [LANES-1:0][WIDTH-1:0]  in_i,
    input  logic signed [LANES-1:0][WIDTH-1:0]  in_q,
    input  logic                                din_valid,
    input  logic                                fft_mode,
    output logic signed [LANES-1:0][WIDTH:0]    dout_re,
    output logic signed [LANES-1:0][WIDTH:0]    dout_im,
    output logic                                dout_valid,
    output logic                                dout_sel
);
    localparam int PW = $clog2(SPAN + 1);
    localparam int IW = $clog2(SPAN);
    localparam logic [PW-1:0] P_LAST = PW'(SPAN - 1);
    localparam logic [PW-1:0] P_FULL = PW'(SPAN);
    localparam logic [PW-1:0] P_HALF = PW'(SPAN / 2);

    typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

    state_t        state_q, state_nxt;
    logic [PW-1:0] wp_q, wp_nxt, rp_q, rp_nxt, wp_inc, wp_fill;
    logic          mode_q, mode_nxt, pend_q, pend_nxt;
    logic          wr_en, wr_diff, rot_cyc, out_vld, out_sel;
    logic [IW-1:0] wr_idx, rd_idx;

    logic [LANES-1:0][WIDTH:0] sum_re, sum_im, drn_re, drn_im;

    assign wp_inc = wp_q + PW'(1);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fft_bfly_lane #(.WIDTH(WIDTH), .SPAN(SPAN), .IW(IW)) u_lane (
            .clk      (clk),
            .wr_en    (wr_en),
            .wr_diff  (wr_diff),
            .wr_idx   (wr_idx),
            .rd_idx   (rd_idx),
            .in_re    (in_i[l]),
            .in_im    (in_q[l]),
            .rot      (rot_cyc),
            .rot_mode (mode_q),
            .sum_re   (sum_re[l]),
            .sum_im   (sum_im[l]),
            .drn_re   (drn_re[l]),
            .drn_im   (drn_im[l])
        );
    end

    // Control state: FSM, pointers, frame mode of the buffered frame and the
    // mode captured for a frame that starts filling during DRAIN.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            wp_q    <= wp_nxt;
            rp_q    <= rp_nxt;
            mode_q  <= mode_nxt;
            pend_q  <= pend_nxt;
        end
    end

    // Next-state, buffer access and output selection.
    always_comb begin
        state_nxt = state_q;
        wp_nxt    = wp_q;
        rp_nxt    = rp_q;
        mode_nxt  = mode_q;
        pend_nxt  = pend_q;
        wp_fill   = wp_q;
        wr_en     = 1'b0;
        wr_diff   = 1'b0;
        wr_idx    = wp_q[IW-1:0];
        rd_idx    = wp_q[IW-1:0];
        rot_cyc   = 1'b0;
        out_vld   = 1'b0;
        out_sel   = 1'b0;
        case (state_q)
            IDLE: if (din_valid) begin
                wr_en     = 1'b1;
                wr_idx    = '0;
                wp_nxt    = PW'(1);
                mode_nxt  = fft_mode;
                state_nxt = FILL;
            end
            FILL: if (din_valid) begin
                wr_en = 1'b1;
                if (wp_q == P_LAST) begin
                    wp_nxt    = '0;
                    state_nxt = BFLY;
                end else begin
                    wp_nxt = wp_inc;
                end
            end
            BFLY: if (din_valid) begin
                wr_en   = 1'b1;
                wr_diff = 1'b1;
                out_vld = 1'b1;
                if (wp_q == P_LAST) begin
                    wp_nxt    = '0;
                    rp_nxt    = '0;
                    state_nxt = DRAIN;
                end else begin
                    wp_nxt = wp_inc;
                end
            end
            DRAIN: begin
                // wp never overtakes rp, so a same-slot fill write lands after
                // the diff it replaces has been read this cycle.
                rd_idx  = rp_q[IW-1:0];
                out_vld = 1'b1;
                out_sel = 1'b1;
                rot_cyc = ROT_EN && (rp_q >= P_HALF);
                rp_nxt  = rp_q + PW'(1);
                if (din_valid) begin
                    wr_en   = 1'b1;
                    wp_fill = wp_inc;
                    if (wp_q == '0) pend_nxt = fft_mode;
                end
                wp_nxt = wp_fill;
                if (rp_q == P_LAST) begin
                    rp_nxt   = '0;
                    mode_nxt = (din_valid && wp_q == '0) ? fft_mode : pend_q;
                    if (wp_fill == P_FULL) begin
                        wp_nxt    = '0;
                        state_nxt = BFLY;
                    end else if (wp_fill != '0) begin
                        state_nxt = FILL;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered result beat; data and selector hold while no beat is emitted.
    always_ff @(posedge clk) begin
        if (rstn) begin
            dout_valid <= 1'b0;
            dout_sel   <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            dout_valid <= out_vld;
            if (out_vld) begin
                dout_sel <= out_sel;
                dout_re  <= out_sel ? drn_re : sum_re;
                dout_im  <= out_sel ? drn_im : sum_im;
            end
        end
    end
endmodule

// File: tb/tb_fft_bfly_stage.sv
// Randomized bench for fft_bfly_stage with a frame-level reference model.
module tb_fft_bfly_stage;
    localparam int WIDTH  = 9;
    localparam int LANES  = 2;
    localparam int SPAN   = 2;
    localparam bit ROT_EN = 1'b1;

    typedef logic signed [LANES-1:0][WIDTH:0] vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic signed [LANES-1:0][WIDTH-1:0] in_i = '0, in_q = '0;
    logic din_valid = 1'b0, fft_mode = 1'b0;
    vec_t dout_re, dout_im;
    logic dout_valid, dout_sel;

    always #5 clk = ~clk;

    fft_bfly_stage #(.WIDTH(WIDTH), .LANES(LANES), .SPAN(SPAN), .ROT_EN(ROT_EN)) dut (
        .clk(clk), .rstn(rstn), .in_i(in_i), .in_q(in_q), .din_valid(din_valid),
        .fft_mode(fft_mode), .dout_re(dout_re), .dout_im(dout_im),
        .dout_valid(dout_valid), .dout_sel(dout_sel)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frames of 2*SPAN beats, partners k and k+SPAN.
    int   fcnt = 0;
    bit   fmode = 1'b0;
    int   fr [SPAN][LANES];
    int   fi [SPAN][LANES];
    vec_t dre [SPAN];
    vec_t dim [SPAN];
    vec_t pend_re[$], pend_im[$];
    vec_t exp_re = '0, exp_im = '0;
    bit   exp_v = 1'b0, exp_sel = 1'b0;

    int obs_re0[$], obs_im0[$], obs_sel[$];
    int run = 0, max_run = 0;

    task automatic model_edge();
        int k, xr, xi, sr, si, dr, di, t;
        if (rstn) begin
            fcnt = 0;
            pend_re.delete();
            pend_im.delete();
            exp_v = 1'b0; exp_sel = 1'b0; exp_re = '0; exp_im = '0;
            return;
        end
        exp_v = 1'b0;
        if (pend_re.size() > 0) begin
            exp_re = pend_re.pop_front();
            exp_im = pend_im.pop_front();
            exp_sel = 1'b1;
            exp_v = 1'b1;
        end
        if (din_valid) begin
            if (fcnt == 0) fmode = fft_mode;
            for (int l = 0; l < LANES; l++) begin
                xr = $signed(in_i[l]);
                xi = $signed(in_q[l]);
                if (fcnt < SPAN) begin
                    fr[fcnt][l] = xr;
                    fi[fcnt][l] = xi;
                end else begin
                    k  = fcnt - SPAN;
                    sr = fr[k][l] + xr;
                    si = fi[k][l] + xi;
                    dr = fr[k][l] - xr;
                    di = fi[k][l] - xi;
                    if (ROT_EN && k >= SPAN / 2) begin
                        t = dr;
                        if (!fmode) begin dr = di;  di = -t; end
                        else        begin dr = -di; di = t;  end
                    end
                    exp_re[l] = (WIDTH+1)'(sr);
                    exp_im[l] = (WIDTH+1)'(si);
                    dre[k][l] = (WIDTH+1)'(dr);
                    dim[k][l] = (WIDTH+1)'(di);
                end
            end
            if (fcnt >= SPAN) begin
                exp_sel = 1'b0;
                exp_v = 1'b1;
            end
            fcnt++;
            if (fcnt == 2 * SPAN) begin
                for (int j = 0; j < SPAN; j++) begin
                    pend_re.push_back(dre[j]);
                    pend_im.push_back(dim[j]);
                end
                fcnt = 0;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit v, input bit m);
        rstn = rst; din_valid = v; fft_mode = m;
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", dout_valid, exp_v);
        chk("re", dout_re, exp_re);
        chk("im", dout_im, exp_im);
        if (exp_v) chk("sel", dout_sel, exp_sel);
        if (dout_valid) begin
            obs_re0.push_back($signed(dout_re[0]));
            obs_im0.push_back($signed(dout_im[0]));
            obs_sel.push_back(int'(dout_sel));
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic set_beat(input int r0, input int r1, input int q0, input int q1);
        in_i[0] = WIDTH'(r0); in_i[1] = WIDTH'(r1);
        in_q[0] = WIDTH'(q0); in_q[1] = WIDTH'(q1);
    endtask

    task automatic rnd_beat();
        for (int l = 0; l < LANES; l++) begin
            in_i[l] = WIDTH'($urandom);
            in_q[l] = WIDTH'($urandom);
        end
    endtask

    task automatic clr_obs();
        obs_re0.delete(); obs_im0.delete(); obs_sel.delete();
        max_run = 0;
    endtask

    task automatic chk_obs(input string tag, input int er[4], input int ei[4], input int es[4]);
        chk({tag, "_n"}, obs_re0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_re0.size()) begin
                chk({tag, "_re"}, obs_re0[i], er[i]);
                chk({tag, "_im"}, obs_im0[i], ei[i]);
                chk({tag, "_sel"}, obs_sel[i], es[i]);
            end
        end
    endtask

    int r1_re[4] = '{6, 9, -4, 0};
    int r1_im[4] = '{0, 0, 0, 5};
    int r2_im[4] = '{0, 0, 0, -5};
    int sels[4]  = '{0, 0, 1, 1};
    int ext_re[4] = '{-1, -1, -511, -511};
    int ext_im[4] = '{-1, -1, -511, 511};
    int b1[4] = '{1, 2, 5, 7};

    initial begin
        // Reset state.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_re", dout_re, 0);

        // Real-only frame, FFT mode.
        clr_obs();
        for (int b = 0; b < 4; b++) begin
            set_beat(b1[b], -3 * b1[b], 0, 0);
            cyc(0, 1, 0);
        end
        repeat (3) cyc(0, 0, 0);
        chk_obs("fft", r1_re, r1_im, sels);

        // Same frame in IFFT mode, mode toggled after the first beat.
        clr_obs();
        for (int b = 0; b < 4; b++) begin
            set_beat(b1[b], 2 * b1[b], 0, 0);
            cyc(0, 1, b == 0);
        end
        repeat (3) cyc(0, 0, 0);
        chk_obs("ifft", r1_re, r2_im, sels);

        // Extremes: -256 against +255.
        clr_obs();
        for (int b = 0; b < 4; b++) begin
            if (b < 2) set_beat(-256, -256, -256, -256);
            else       set_beat(255, 255, 255, 255);
            cyc(0, 1, 0);
        end
        repeat (3) cyc(0, 0, 0);
        chk_obs("ext", ext_re, ext_im, sels);

        // Three frames back-to-back: one gap-free run of 12 beats.
        clr_obs();
        for (int b = 0; b < 12; b++) begin
            rnd_beat();
            cyc(0, 1, 1'($urandom));
        end
        repeat (4) cyc(0, 0, 0);
        chk("b2b_run", max_run, 12);

        // Gaps inside BFLY, then silence through DRAIN.
        for (int b = 0; b < 4; b++) begin
            rnd_beat();
            cyc(0, 1, 0);
            if (b >= 2) repeat (3) cyc(0, 0, 1);
        end
        repeat (3) cyc(0, 0, 0);

        // Reset during DRAIN, then a partial frame must stay silent.
        for (int b = 0; b < 4; b++) begin
            rnd_beat();
            cyc(0, 1, 0);
        end
        cyc(1, 0, 0);
        clr_obs();
        for (int b = 0; b < 2; b++) begin
            rnd_beat();
            cyc(0, 1, 0);
        end
        repeat (3) cyc(0, 0, 0);
        chk("rst_abandon", obs_re0.size(), 0);
        cyc(1, 0, 0);

        // Randomized traffic with random gaps, modes and rare resets.
        for (int c = 0; c < 1500; c++) begin
            rnd_beat();
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
        end
        repeat (6) cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
